// File: rtl/fp_mul_pkg.sv
// rtl/fp_mul_pkg.sv - shared state encoding, widths and flag bundle for the FP multiplier arbiter
package fp_mul_pkg;

    localparam int FP_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    typedef struct packed {
        logic exception;
        logic overflow;
        logic underflow;
    } rsp_flags_t;

endpackage

// File: rtl/fp_mul_arbiter_if.sv
// rtl/fp_mul_arbiter_if.sv - request/response bundle between requesters and the shared multiplier
// Ports: none; signals are req_valid/req_ready/req_a/req_b (one lane per requester, packed)
// and rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_exception/rsp_overflow/rsp_underflow.
// master = requester side, slave = arbiter side.
interface fp_mul_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]                     req_valid;
    logic [NUM_REQ-1:0]                     req_ready;
    logic [NUM_REQ*fp_mul_pkg::FP_W-1:0]    req_a;
    logic [NUM_REQ*fp_mul_pkg::FP_W-1:0]    req_b;
    logic                                   rsp_valid;
    logic                                   rsp_ready;
    logic [ID_W-1:0]                        rsp_id;
    logic [fp_mul_pkg::FP_W-1:0]            rsp_result;
    logic                                   rsp_exception;
    logic                                   rsp_overflow;
    logic                                   rsp_underflow;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result,
               rsp_exception, rsp_overflow, rsp_underflow
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result,
               rsp_exception, rsp_overflow, rsp_underflow
    );
endinterface

// File: rtl/Multiplier24Bit.sv
// rtl/Multiplier24Bit.sv - combinational single-precision multiplier, round-to-nearest-even, denormals flushed
// Ports: a_operand, b_operand (IEEE-754 single) -> result, Exception (Inf/NaN operand),
// Overflow (exponent above 254), Underflow (exponent below 1).
module Multiplier24Bit (
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    output logic [31:0] result,
    output logic        Exception,
    output logic        Overflow,
    output logic        Underflow
);
    logic        sign, zero_a, zero_b, nan, norm, sticky, round_up;
    logic [7:0]  exp_a, exp_b;
    logic [23:0] man_a, man_b, keep, man_r;
    logic [47:0] prod;
    logic [9:0]  exp_sum;

    always_comb begin
        sign     = a_operand[31] ^ b_operand[31];
        exp_a    = a_operand[30:23];
        exp_b    = b_operand[30:23];
        zero_a   = (exp_a == 8'd0);
        zero_b   = (exp_b == 8'd0);
        man_a    = {!zero_a, a_operand[22:0]};
        man_b    = {!zero_b, b_operand[22:0]};
        prod     = 48'(man_a) * 48'(man_b);
        norm     = prod[47];
        // keep = 23 fraction bits plus guard bit, aligned to the leading one.
        keep     = norm ? prod[46:23] : prod[45:22];
        sticky   = norm ? |prod[22:0] : |prod[21:0];
        round_up = keep[0] & (sticky | keep[1]);
        man_r    = {1'b0, keep[23:1]} + {23'd0, round_up};
        // Biased sum kept unsigned: result exponent is exp_sum - 127.
        exp_sum  = {2'b00, exp_a} + {2'b00, exp_b} + {9'd0, norm} + {9'd0, man_r[23]};

        Exception = (&exp_a) | (&exp_b);
        nan       = ((&exp_a) & (|a_operand[22:0])) | ((&exp_b) & (|b_operand[22:0]))
                  | ((&exp_a) & zero_b) | ((&exp_b) & zero_a);
        Overflow  = !Exception && !zero_a && !zero_b && (exp_sum > 10'd381);
        Underflow = !Exception && !zero_a && !zero_b && (exp_sum < 10'd128);

        if (nan)
            result = 32'h7FC0_0000;
        else if (Exception || Overflow)
            result = {sign, 8'hFF, 23'd0};
        else if (zero_a || zero_b || Underflow)
            result = {sign, 31'd0};
        else
            result = {sign, 8'(exp_sum - 10'd127), man_r[22:0]};
    end
endmodule

// File: rtl/rr_grant.sv
// rtl/rr_grant.sv - combinational round-robin picker starting one past the previous winner
// Ports: req (request vector), last_grant (previous winner index) ->
// grant (one-hot), grant_idx (encoded winner), grant_any (some request present).
module rr_grant #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_any
);
    always_comb begin
        int lane;
        lane      = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        // Offset NUM_REQ wraps back to last_grant itself, so a lone repeat requester still wins.
        for (int off = 1; off <= NUM_REQ; off++) begin
            lane = (int'(last_grant) + off) % NUM_REQ;
            if (!grant_any && req[lane]) begin
                grant_any   = 1'b1;
                grant[lane] = 1'b1;
                grant_idx   = ID_W'(lane);
            end
        end
    end
endmodule

// File: rtl/fp_mul_arbiter.sv
// rtl/fp_mul_arbiter.sv - round-robin shares one multicycle FP multiplier among NUM_REQ requesters
// Ports: clk, rst_n (async active-low), bus (slave side of fp_mul_arbiter_if: per-lane
// requests in, tagged registered response out), busy (high whenever not IDLE).
module fp_mul_arbiter
    import fp_mul_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MUL_LAT = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    fp_mul_arbiter_if.slave bus,
    output logic            busy
);
    localparam int              CNT_W    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [ID_W-1:0]  LAST_RST = ID_W'(NUM_REQ - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [FP_W-1:0]    op_a_q, op_b_q;
    logic [ID_W-1:0]    id_q, last_grant_q;
    logic               rsp_valid_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [FP_W-1:0]    rsp_result_q;
    rsp_flags_t         rsp_flags_q;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any;
    logic [FP_W-1:0]    mul_result;
    logic               mul_exc, mul_ovf, mul_unf;

    rr_grant #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr_grant (
        .req        (bus.req_valid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_any  (grant_any)
    );

    // Inputs come only from registers held through EXEC, so this path may be multicycle-constrained.
    Multiplier24Bit u_mul (
        .a_operand (op_a_q),
        .b_operand (op_b_q),
        .result    (mul_result),
        .Exception (mul_exc),
        .Overflow  (mul_ovf),
        .Underflow (mul_unf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        bus.req_ready = '0;
        busy          = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                bus.req_ready = grant;
                if (grant_any) state_d = EXEC;
            end
            EXEC:    if (cnt_q == '0) state_d = RESP;
            // rsp_valid is always set in RESP, so rsp_ready alone completes the handshake.
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            id_q         <= '0;
            last_grant_q <= LAST_RST;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (grant_any) begin
                    op_a_q       <= bus.req_a[grant_idx*FP_W +: FP_W];
                    op_b_q       <= bus.req_b[grant_idx*FP_W +: FP_W];
                    id_q         <= grant_idx;
                    last_grant_q <= grant_idx;
                    cnt_q        <= CNT_LOAD;
                end
                EXEC: if (cnt_q != '0) begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end else begin
                    rsp_result_q <= mul_result;
                    rsp_flags_q  <= '{exception: mul_exc, overflow: mul_ovf, underflow: mul_unf};
                    rsp_id_q     <= id_q;
                    rsp_valid_q  <= 1'b1;
                end
                RESP: if (bus.rsp_ready) rsp_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_id        = rsp_id_q;
    assign bus.rsp_result    = rsp_result_q;
    assign bus.rsp_exception = rsp_flags_q.exception;
    assign bus.rsp_overflow  = rsp_flags_q.overflow;
    assign bus.rsp_underflow = rsp_flags_q.underflow;
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb/tb_fp_mul_arbiter.sv - self-checking bench for fp_mul_arbiter (MUL_LAT=2 and MUL_LAT=1 builds)
module tb_fp_mul_arbiter;
    localparam int NUM_REQ = 4;
    localparam int MUL_LAT = 2;
    localparam int ID_W    = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic busy, busy1;
    int   n_cmp = 0;
    int   n_err = 0;

    fp_mul_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();
    fp_mul_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus1 ();

    fp_mul_arbiter #(.NUM_REQ(NUM_REQ), .MUL_LAT(MUL_LAT), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave), .busy(busy));
    fp_mul_arbiter #(.NUM_REQ(NUM_REQ), .MUL_LAT(1), .ID_W(ID_W)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .busy(busy1));

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Exact float encoding of a signed integer magnitude below 2^24.
    function automatic logic [31:0] int_to_fp(input bit s, input int unsigned n);
        int p;
        int unsigned frac;
        p = 0;
        for (int i = 0; i < 24; i++) if (n[i]) p = i;
        frac = (n << (23 - p)) & 32'h007F_FFFF;
        return {s, 8'(127 + p), frac[22:0]};
    endfunction

    task automatic do_reset();
        bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b0;
        bus1.req_valid = '0; bus1.req_a = '0; bus1.req_b = '0; bus1.rsp_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic set_lane(input int lane, input logic [31:0] a, input logic [31:0] b);
        bus.req_a[lane*32 +: 32] = a;
        bus.req_b[lane*32 +: 32] = b;
        bus.req_valid[lane] = 1'b1;
    endtask

    task automatic wait_grant(output int lane, output bit to);
        int n;
        n = 0; lane = -1; to = 0;
        @(negedge clk);
        while (bus.req_ready == '0 && n < 30) begin @(negedge clk); n++; end
        if (bus.req_ready == '0) to = 1;
        else for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) lane = i;
        @(posedge clk); #1;
        if (lane >= 0) bus.req_valid[lane] = 1'b0;
    endtask

    task automatic wait_idle(output bit to);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 30) begin @(negedge clk); n++; end
        to = busy;
        @(posedge clk); #1;
    endtask

    task automatic run_op(input int lane, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [ID_W-1:0] id, output logic [31:0] res,
                          output logic [2:0] flg, output bit to);
        int n;
        n = 0; lat = 0; id = '0; res = '0; flg = '0; to = 0;
        set_lane(lane, a, b);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        while (!bus.req_ready[lane] && n < 30) begin @(negedge clk); n++; end
        if (!bus.req_ready[lane]) begin
            to = 1;
            @(posedge clk); #1 bus.req_valid[lane] = 1'b0;
            return;
        end
        @(posedge clk); #1 bus.req_valid[lane] = 1'b0;
        do begin @(negedge clk); lat++; end while (!bus.rsp_valid && lat < 30);
        to  = !bus.rsp_valid;
        id  = bus.rsp_id;
        res = bus.rsp_result;
        flg = {bus.rsp_exception, bus.rsp_overflow, bus.rsp_underflow};
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset rsp_valid: got %b want 0", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_id !== 2'd0) begin n_err++; $display("FAIL reset rsp_id: got %0d want 0", bus.rsp_id); end
        n_cmp++; if (bus.rsp_result !== 32'd0) begin n_err++; $display("FAIL reset rsp_result: got %h want 0", bus.rsp_result); end
        n_cmp++; if ({bus.rsp_exception, bus.rsp_overflow, bus.rsp_underflow} !== 3'b000) begin n_err++; $display("FAIL reset flags: got %b want 000", {bus.rsp_exception, bus.rsp_overflow, bus.rsp_underflow}); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b want 0", busy); end
        n_cmp++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL reset req_ready: got %b want 0000", bus.req_ready); end
        n_cmp++; if (bus1.rsp_valid !== 1'b0 || busy1 !== 1'b0) begin n_err++; $display("FAIL reset lat1 idle: got %b%b want 00", bus1.rsp_valid, busy1); end
    endtask

    task automatic test_single();
        set_lane(0, 32'h4010_0000, 32'h40F0_0000);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL single grant: got %b want 0001", bus.req_ready); end
        // Lane 0 keeps requesting; no further grant may appear while the operation is in flight.
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            if (c == 3) bus.req_valid[0] = 1'b0;
            @(negedge clk);
            n_cmp++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL single ready_T+%0d: got %b want 0000", c, bus.req_ready); end
            n_cmp++; if (bus.rsp_valid !== (c == 3)) begin n_err++; $display("FAIL single rsp_valid_T+%0d: got %b want %b", c, bus.rsp_valid, c == 3); end
        end
        n_cmp++; if (bus.rsp_result !== 32'h4187_0000) begin n_err++; $display("FAIL single result: got %h want 41870000", bus.rsp_result); end
        n_cmp++; if (bus.rsp_id !== 2'd0) begin n_err++; $display("FAIL single id: got %0d want 0", bus.rsp_id); end
        n_cmp++; if ({bus.rsp_exception, bus.rsp_overflow, bus.rsp_underflow} !== 3'b000) begin n_err++; $display("FAIL single flags: got %b want 000", {bus.rsp_exception, bus.rsp_overflow, bus.rsp_underflow}); end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL single after_hs: got %b%b want 00", bus.rsp_valid, busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        int  lane;
        bit  to;
        int  order2 [2] = '{1, 3};
        do_reset();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_lane(i, int_to_fp(0, i + 1), int_to_fp(0, 3));
        for (int k = 0; k < NUM_REQ; k++) begin
            wait_grant(lane, to);
            n_cmp++; if (to || lane != k) begin n_err++; $display("FAIL rr grant%0d: got %0d want %0d", k, lane, k); end
        end
        wait_idle(to);
        set_lane(1, int_to_fp(0, 7), int_to_fp(0, 9));
        set_lane(3, int_to_fp(0, 11), int_to_fp(0, 13));
        for (int k = 0; k < 2; k++) begin
            wait_grant(lane, to);
            n_cmp++; if (to || lane != order2[k]) begin n_err++; $display("FAIL rr regrant%0d: got %0d want %0d", k, lane, order2[k]); end
        end
        wait_idle(to);
        n_cmp++; if (to) begin n_err++; $display("FAIL rr idle: got busy want idle"); end
    endtask

    task automatic test_back_pressure();
        int lane;
        bit to;
        int n;
        bus.rsp_ready = 1'b0;
        set_lane(2, 32'h4120_0000, 32'h41C8_0000);
        wait_grant(lane, to);
        n_cmp++; if (to || lane != 2) begin n_err++; $display("FAIL bp grant: got %0d want 2", lane); end
        set_lane(0, 32'h3F80_0000, 32'h3F80_0000);
        n = 0;
        @(negedge clk);
        while (!bus.rsp_valid && n < 20) begin
            n_cmp++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL bp exec_ready: got %b want 0000", bus.req_ready); end
            @(negedge clk); n++;
        end
        n_cmp++; if (n != MUL_LAT) begin n_err++; $display("FAIL bp latency: got %0d want %0d", n + 1, MUL_LAT + 1); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_result !== 32'h437A_0000)
                begin n_err++; $display("FAIL bp hold%0d: got v=%b id=%0d r=%h want v=1 id=2 r=437a0000", i, bus.rsp_valid, bus.rsp_id, bus.rsp_result); end
            n_cmp++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL bp hold_ready%0d: got %b want 0000", i, bus.req_ready); end
            @(posedge clk); #1;
            @(negedge clk);
        end
        // Sixth stalled cycle; release the back-pressure for the following one.
        @(posedge clk); #1 bus.rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL bp hs_cycle: got v=%b rdy=%b want v=1 rdy=0000", bus.rsp_valid, bus.req_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL bp next_grant: got v=%b rdy=%b want v=0 rdy=0001", bus.rsp_valid, bus.req_ready); end
        @(posedge clk); #1 bus.req_valid[0] = 1'b0;
        wait_idle(to);
    endtask

    task automatic test_flags();
        int              lat;
        logic [ID_W-1:0] id;
        logic [31:0]     res;
        logic [2:0]      flg;
        bit              to;
        run_op(1, 32'h7F00_0000, 32'h7F00_0000, lat, id, res, flg, to);
        n_cmp++; if (to || res !== 32'h7F80_0000 || flg !== 3'b010 || id !== 2'd1)
            begin n_err++; $display("FAIL overflow: got r=%h f=%b id=%0d want r=7f800000 f=010 id=1", res, flg, id); end
        run_op(2, 32'h0080_0000, 32'h0080_0000, lat, id, res, flg, to);
        n_cmp++; if (to || res !== 32'h0000_0000 || flg !== 3'b001 || id !== 2'd2)
            begin n_err++; $display("FAIL underflow: got r=%h f=%b id=%0d want r=0 f=001 id=2", res, flg, id); end
        run_op(1, 32'h7F80_0000, 32'hC000_0000, lat, id, res, flg, to);
        n_cmp++; if (to || res !== 32'hFF80_0000 || flg !== 3'b100 || id !== 2'd1)
            begin n_err++; $display("FAIL exception: got r=%h f=%b id=%0d want r=ff800000 f=100 id=1", res, flg, id); end
    endtask

    task automatic test_reset_mid();
        int              lane, lat;
        logic [ID_W-1:0] id;
        logic [31:0]     res;
        logic [2:0]      flg;
        bit              to;
        bus.rsp_ready = 1'b1;
        set_lane(2, int_to_fp(0, 3), int_to_fp(0, 4));
        wait_grant(lane, to);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || bus.req_ready !== 4'b0000)
            begin n_err++; $display("FAIL midrst outputs: got v=%b busy=%b rdy=%b want 0", bus.rsp_valid, busy, bus.req_ready); end
        n_cmp++; if (bus.rsp_result !== 32'd0 || bus.rsp_id !== 2'd0)
            begin n_err++; $display("FAIL midrst rsp: got r=%h id=%0d want 0", bus.rsp_result, bus.rsp_id); end
        @(posedge clk); #1 rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_cmp++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL midrst stale%0d: got v=%b busy=%b want 0", c, bus.rsp_valid, busy); end
            @(posedge clk); #1;
        end
        run_op(3, int_to_fp(0, 5), int_to_fp(1, 6), lat, id, res, flg, to);
        n_cmp++; if (to || lat != MUL_LAT + 1 || id !== 2'd3 || res !== int_to_fp(1, 30) || flg !== 3'b000)
            begin n_err++; $display("FAIL midrst lane3: got lat=%0d id=%0d r=%h f=%b want lat=%0d id=3 r=%h f=000", lat, id, res, flg, MUL_LAT + 1, int_to_fp(1, 30)); end
    endtask

    typedef struct {
        int          id;
        logic [31:0] res;
        int          gcyc;
    } exp_t;

    task automatic test_random();
        exp_t        q[$];
        exp_t        e;
        logic [31:0] lane_prod [NUM_REQ];
        int          last, drop, want, ia, ib;
        bit          sa, sb, prev_v;
        do_reset();
        last = NUM_REQ - 1; drop = -1; prev_v = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (drop >= 0) bus.req_valid[drop] = 1'b0;
            drop = -1;
            for (int l = 0; l < NUM_REQ; l++) begin
                if (!bus.req_valid[l] && cyc < 300 && $urandom_range(0, 2) == 0) begin
                    ia = int'($urandom_range(1, 4095)); ib = int'($urandom_range(1, 4095));
                    sa = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
                    set_lane(l, int_to_fp(sa, ia), int_to_fp(sb, ib));
                    lane_prod[l] = int_to_fp(sa ^ sb, ia * ib);
                end
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            if (cyc >= 300 && bus.req_valid == '0 && q.size() == 0 && !bus.rsp_valid) break;
            @(negedge clk);
            if (bus.req_ready != '0) begin
                want = -1;
                for (int off = 1; off <= NUM_REQ; off++)
                    if (want < 0 && bus.req_valid[(last + off) % NUM_REQ]) want = (last + off) % NUM_REQ;
                n_cmp++; if (want < 0 || bus.req_ready !== 4'(1 << want))
                    begin n_err++; $display("FAIL rand grant@%0d: got %b want lane %0d", cyc, bus.req_ready, want); end
                if (want >= 0) begin
                    q.push_back('{id: want, res: lane_prod[want], gcyc: cyc});
                    last = want; drop = want;
                end
            end
            if (bus.rsp_valid && !prev_v) begin
                n_cmp++; if (q.size() == 0 || cyc - q[0].gcyc != MUL_LAT + 1)
                    begin n_err++; $display("FAIL rand latency@%0d: got %0d want %0d", cyc, (q.size() == 0) ? -1 : cyc - q[0].gcyc, MUL_LAT + 1); end
            end
            if (bus.rsp_valid && bus.rsp_ready && q.size() != 0) begin
                e = q.pop_front();
                n_cmp++; if (int'(bus.rsp_id) != e.id || bus.rsp_result !== e.res ||
                             {bus.rsp_exception, bus.rsp_overflow, bus.rsp_underflow} !== 3'b000)
                    begin n_err++; $display("FAIL rand rsp@%0d: got id=%0d r=%h want id=%0d r=%h", cyc, bus.rsp_id, bus.rsp_result, e.id, e.res); end
            end
            prev_v = bus.rsp_valid;
            @(posedge clk); #1;
        end
        n_cmp++; if (q.size() != 0 || bus.req_valid != '0)
            begin n_err++; $display("FAIL rand drain: got %0d queued, valid=%b want 0", q.size(), bus.req_valid); end
        bus.req_valid = '0;
    endtask

    task automatic test_mul_lat1();
        int gc[$];
        int rc[$];
        do_reset();
        bus1.req_a[31:0] = int_to_fp(0, 3);
        bus1.req_b[31:0] = int_to_fp(0, 5);
        bus1.req_valid   = 4'b0001;
        bus1.rsp_ready   = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus1.req_ready[0]) gc.push_back(c);
            if (bus1.rsp_valid) begin
                rc.push_back(c);
                n_cmp++; if (bus1.rsp_result !== 32'h4170_0000 || bus1.rsp_id !== 2'd0)
                    begin n_err++; $display("FAIL lat1 rsp@%0d: got r=%h id=%0d want r=41700000 id=0", c, bus1.rsp_result, bus1.rsp_id); end
            end
            @(posedge clk); #1;
        end
        bus1.req_valid = '0;
        n_cmp++; if (gc.size() != 5 || rc.size() != 5)
            begin n_err++; $display("FAIL lat1 counts: got %0d grants %0d rsps want 5 5", gc.size(), rc.size()); end
        for (int i = 0; i < gc.size() && i < rc.size(); i++) begin
            n_cmp++; if (rc[i] - gc[i] != 2 || gc[i] != 3 * i)
                begin n_err++; $display("FAIL lat1 timing%0d: got grant %0d rsp %0d want grant %0d rsp %0d", i, gc[i], rc[i], 3 * i, 3 * i + 2); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_back_pressure();
        test_flags();
        test_reset_mid();
        test_random();
        test_mul_lat1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
